// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: bundles the requester strobes, the transmitter
// handshake and the scheduler status flags into one interface.
// master = requester/transmitter side, slave = the scheduler itself.
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_BYTES  = 2
);
  logic [DATA_WIDTH-1:0]           RF_RD_DATA;
  logic                            RF_RD_VLD;
  logic [ALU_BYTES*DATA_WIDTH-1:0] ALU_OUT;
  logic                            ALU_OUT_VLD;
  logic                            TX_BUSY;
  logic [DATA_WIDTH-1:0]           TX_P_DATA;
  logic                            TX_D_VALID;
  logic                            RF_FULL;
  logic                            ALU_FULL;
  logic                            OVF;

  modport master (
    output RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    input  TX_P_DATA, TX_D_VALID, RF_FULL, ALU_FULL, OVF
  );

  modport slave (
    input  RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY,
    output TX_P_DATA, TX_D_VALID, RF_FULL, ALU_FULL, OVF
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between the register-file
// read path (single byte) and the ALU result path (multi-byte word, LSB
// first). One holding buffer per requester, an arbiter, and a handshake
// FSM that follows the transmitter busy flag to frame completion.
// Build option: define TX_SCHED_RR_EN for round-robin arbitration;
// without it RF has fixed priority over ALU.
module uart_tx_sched #(
  parameter int DATA_WIDTH   = 8,
  parameter int ALU_BYTES    = 2,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic           CLK,
  input logic           rst,
  uart_tx_sched_if.slave bus
);

  localparam int ALU_W = ALU_BYTES * DATA_WIDTH;
  localparam int IDX_W = (ALU_BYTES > 1) ? $clog2(ALU_BYTES) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ALU_BYTES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  typedef enum logic {
    GNT_RF  = 1'b0,
    GNT_ALU = 1'b1
  } gnt_t;

  state_t                state_q, state_d;
  gnt_t                  gnt_q, gnt_d;
  gnt_t                  arb_gnt;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rf_buf_q, rf_buf_d;
  logic                  rf_full_q, rf_full_d;
  logic [ALU_W-1:0]      alu_buf_q, alu_buf_d;
  logic                  alu_full_q, alu_full_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  rf_rel, alu_rel;

`ifdef TX_SCHED_RR_EN
  gnt_t                  prio_q, prio_d;

  // Round-robin pick: contested grants go to whichever side holds priority.
  always_comb begin
    arb_gnt = GNT_RF;
    if (rf_full_q && alu_full_q) begin
      arb_gnt = prio_q;
    end else if (rf_full_q) begin
      arb_gnt = GNT_RF;
    end else begin
      arb_gnt = GNT_ALU;
    end
  end

  // Hand priority to the other requester once a grant completes.
  always_comb begin
    prio_d = prio_q;
    if (rf_rel) begin
      prio_d = GNT_ALU;
    end else if (alu_rel) begin
      prio_d = GNT_RF;
    end else begin
      prio_d = prio_q;
    end
  end

  // Priority pointer register, resets favouring RF.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      prio_q <= GNT_RF;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Fixed priority pick: RF always wins a contested grant.
  always_comb begin
    arb_gnt = GNT_ALU;
    if (rf_full_q) begin
      arb_gnt = GNT_RF;
    end else begin
      arb_gnt = GNT_ALU;
    end
  end
`endif

  // Handshake FSM next-state: grant, issue, await busy rise, await busy fall.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rf_rel  = 1'b0;
    alu_rel = 1'b0;
    case (state_q)
      IDLE: begin
        if ((rf_full_q || alu_full_q) && !bus.TX_BUSY) begin
          state_d = LOAD;
          gnt_d   = arb_gnt;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        if (bus.TX_BUSY) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          // Transmitter never picked the byte up: issue it again.
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.TX_BUSY) begin
          if ((gnt_q == GNT_ALU) && (idx_q != LAST_IDX)) begin
            // Stay on the ALU word until every byte has gone out.
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            if (gnt_q == GNT_RF) begin
              rf_rel = 1'b1;
            end else begin
              alu_rel = 1'b1;
            end
          end
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding buffers: capture into an empty (or just-released) slot, else flag overflow.
  always_comb begin
    rf_buf_d   = rf_buf_q;
    rf_full_d  = rf_full_q;
    alu_buf_d  = alu_buf_q;
    alu_full_d = alu_full_q;
    ovf_d      = ovf_q;
    if (bus.RF_RD_VLD) begin
      if (!rf_full_q || rf_rel) begin
        rf_buf_d  = bus.RF_RD_DATA;
        rf_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (rf_rel) begin
      rf_full_d = 1'b0;
    end else begin
      rf_full_d = rf_full_q;
    end
    if (bus.ALU_OUT_VLD) begin
      if (!alu_full_q || alu_rel) begin
        alu_buf_d  = bus.ALU_OUT;
        alu_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (alu_rel) begin
      alu_full_d = 1'b0;
    end else begin
      alu_full_d = alu_full_q;
    end
  end

  // Registered transmitter outputs follow the state being entered.
  always_comb begin
    tx_valid_d = (state_d == LOAD);
    tx_data_d  = '0;
    if (state_d == IDLE) begin
      tx_data_d = '0;
    end else if (gnt_d == GNT_RF) begin
      tx_data_d = rf_buf_q;
    end else begin
      tx_data_d = alu_buf_q[int'(idx_d) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State, buffer and output registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_RF;
      idx_q      <= '0;
      cnt_q      <= '0;
      rf_buf_q   <= '0;
      rf_full_q  <= 1'b0;
      alu_buf_q  <= '0;
      alu_full_q <= 1'b0;
      ovf_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rf_buf_q   <= rf_buf_d;
      rf_full_q  <= rf_full_d;
      alu_buf_q  <= alu_buf_d;
      alu_full_q <= alu_full_d;
      ovf_q      <= ovf_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign bus.TX_P_DATA  = tx_data_q;
  assign bus.TX_D_VALID = tx_valid_q;
  assign bus.RF_FULL    = rf_full_q;
  assign bus.ALU_FULL   = alu_full_q;
  assign bus.OVF        = ovf_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed tests for the UART transmit scheduler with a
// simple transmitter model that raises busy for busy_len cycles per frame.
module tb_uart_tx_sched;
  localparam int DW = 8;
  localparam int AB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.DATA_WIDTH(DW), .ALU_BYTES(AB)) bus();

  uart_tx_sched #(.DATA_WIDTH(DW), .ALU_BYTES(AB), .BUSY_TIMEOUT(15)) dut (
    .CLK (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] vq[$];
  int vt[$];
  int busy_len = 10;
  bit ignore_mode = 1'b0;
  int bcnt = 0;

  // cycle counter and log of every valid pulse (byte and cycle)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.TX_D_VALID === 1'b1) begin
      vq.push_back(bus.TX_P_DATA);
      vt.push_back(cyc);
    end
  end

  // transmitter model: busy rises the cycle after an accepted valid
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.TX_BUSY <= 1'b0;
      bcnt <= 0;
    end else if (bus.TX_BUSY) begin
      if (bcnt == 1) bus.TX_BUSY <= 1'b0;
      bcnt <= bcnt - 1;
    end else if (bus.TX_D_VALID === 1'b1 && !ignore_mode) begin
      bus.TX_BUSY <= 1'b1;
      bcnt <= busy_len;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic strobe_rf(input logic [7:0] d, output int c0);
    @(negedge clk);
    c0 = cyc;
    bus.RF_RD_DATA = d;
    bus.RF_RD_VLD = 1'b1;
    @(negedge clk);
    bus.RF_RD_VLD = 1'b0;
  endtask

  task automatic strobe_alu(input logic [15:0] d, output int c0);
    @(negedge clk);
    c0 = cyc;
    bus.ALU_OUT = d;
    bus.ALU_OUT_VLD = 1'b1;
    @(negedge clk);
    bus.ALU_OUT_VLD = 1'b0;
  endtask

  task automatic strobe_both(input logic [7:0] r, input logic [15:0] a);
    @(negedge clk);
    bus.RF_RD_DATA = r;
    bus.RF_RD_VLD = 1'b1;
    bus.ALU_OUT = a;
    bus.ALU_OUT_VLD = 1'b1;
    @(negedge clk);
    bus.RF_RD_VLD = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus.RF_FULL && !bus.ALU_FULL && !bus.TX_BUSY && !bus.TX_D_VALID) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.RF_RD_VLD = 1'b0;
    bus.ALU_OUT_VLD = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.RF_RD_DATA = '0;
    bus.RF_RD_VLD = 1'b0;
    bus.ALU_OUT = '0;
    bus.ALU_OUT_VLD = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.TX_D_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.TX_D_VALID); end
    checks++; if (bus.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", bus.TX_P_DATA); end
    checks++; if (bus.RF_FULL !== 1'b0) begin errors++; $display("FAIL reset_rf_full: got %b expected 0", bus.RF_FULL); end
    checks++; if (bus.ALU_FULL !== 1'b0) begin errors++; $display("FAIL reset_alu_full: got %b expected 0", bus.ALU_FULL); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.OVF); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.TX_D_VALID !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b expected 0", bus.TX_D_VALID); end
  endtask

  task automatic test_rf_single();
    int c0, clr, base;
    bit ok;
    busy_len = 10;
    base = vq.size();
    clr = -1;
    strobe_rf(8'hA5, c0);
    checks++; if (bus.RF_FULL !== 1'b1) begin errors++; $display("FAIL rf_full_set: got %b expected 1", bus.RF_FULL); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.RF_FULL === 1'b0) begin clr = cyc - c0; break; end
    end
    checks++; if (clr != 14) begin errors++; $display("FAIL rf_release_cycle: got %0d expected 14", clr); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rf_idle_timeout: got busy expected idle"); end
    checks++; if (vq.size() - base != 1) begin errors++; $display("FAIL rf_pulse_count: got %0d expected 1", vq.size() - base); end
    if (vq.size() > base) begin
      checks++; if (vq[base] !== 8'hA5) begin errors++; $display("FAIL rf_byte: got %h expected a5", vq[base]); end
      checks++; if (vt[base] - c0 != 2) begin errors++; $display("FAIL rf_latency: got %0d expected 2", vt[base] - c0); end
    end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL rf_ovf: got %b expected 0", bus.OVF); end
  endtask

  task automatic test_alu();
    int c0, clr, base;
    bit ok;
    busy_len = 10;
    base = vq.size();
    clr = -1;
    strobe_alu(16'h1234, c0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.ALU_FULL === 1'b0) begin clr = cyc - c0; break; end
    end
    checks++; if (clr != 26) begin errors++; $display("FAIL alu_release_cycle: got %0d expected 26", clr); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_idle_timeout: got busy expected idle"); end
    checks++; if (vq.size() - base != 2) begin errors++; $display("FAIL alu_pulse_count: got %0d expected 2", vq.size() - base); end
    if (vq.size() >= base + 2) begin
      checks++; if (vq[base] !== 8'h34) begin errors++; $display("FAIL alu_byte0: got %h expected 34", vq[base]); end
      checks++; if (vq[base+1] !== 8'h12) begin errors++; $display("FAIL alu_byte1: got %h expected 12", vq[base+1]); end
      checks++; if (vt[base+1] - c0 != 14) begin errors++; $display("FAIL alu_byte1_cycle: got %0d expected 14", vt[base+1] - c0); end
    end
  endtask

  task automatic test_priority();
    int base, seen, c0;
    bit ok;
    logic [7:0] exp [7];
    busy_len = 3;
    base = vq.size();
    seen = 0;
    exp[0] = 8'h55; exp[1] = 8'hEF; exp[2] = 8'hBE; exp[3] = 8'h66;
`ifdef TX_SCHED_RR_EN
    exp[4] = 8'hAB; exp[5] = 8'hCD; exp[6] = 8'h77;
`else
    exp[4] = 8'h77; exp[5] = 8'hAB; exp[6] = 8'hCD;
`endif
    strobe_both(8'h55, 16'hBEEF);
    for (int i = 0; i < 100 && seen < 2; i++) begin
      if (bus.TX_D_VALID === 1'b1) seen++;
      if (seen < 2) @(negedge clk);
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL prio_wait_alu: got %0d pulses expected 2", seen); end
    strobe_rf(8'h66, c0);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_idle_timeout1: got busy expected idle"); end
    strobe_both(8'h77, 16'hCDAB);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL prio_idle_timeout2: got busy expected idle"); end
    checks++; if (vq.size() - base != 7) begin errors++; $display("FAIL prio_pulse_count: got %0d expected 7", vq.size() - base); end
    for (int i = 0; i < 7; i++) begin
      if (vq.size() > base + i) begin
        checks++; if (vq[base+i] !== exp[i]) begin errors++; $display("FAIL prio_order[%0d]: got %h expected %h", i, vq[base+i], exp[i]); end
      end
    end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL prio_ovf: got %b expected 0", bus.OVF); end
  endtask

  task automatic test_coincident();
    int c0, base;
    bit ok, seen_busy, hit;
    do_reset();
    busy_len = 5;
    base = vq.size();
    seen_busy = 1'b0;
    hit = 1'b0;
    strobe_rf(8'h31, c0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.TX_BUSY === 1'b1) seen_busy = 1'b1;
      else if (seen_busy) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL coin_busy_fall: got none expected busy fall"); end
    bus.RF_RD_DATA = 8'h32;
    bus.RF_RD_VLD = 1'b1;
    @(negedge clk);
    bus.RF_RD_VLD = 1'b0;
    checks++; if (bus.RF_FULL !== 1'b1) begin errors++; $display("FAIL coin_rf_full: got %b expected 1", bus.RF_FULL); end
    checks++; if (bus.OVF !== 1'b0) begin errors++; $display("FAIL coin_ovf: got %b expected 0", bus.OVF); end
    wait_idle(ok);
    checks++; if (vq.size() - base != 2) begin errors++; $display("FAIL coin_pulse_count: got %0d expected 2", vq.size() - base); end
    if (vq.size() >= base + 2) begin
      checks++; if (vq[base+1] !== 8'h32) begin errors++; $display("FAIL coin_byte: got %h expected 32", vq[base+1]); end
    end
  endtask

  task automatic test_ovf();
    int c0, c1, base;
    bit ok;
    busy_len = 5;
    base = vq.size();
    strobe_rf(8'h41, c0);
    strobe_rf(8'h42, c1);
    checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.OVF); end
    wait_idle(ok);
    checks++; if (vq.size() - base != 1) begin errors++; $display("FAIL ovf_pulse_count: got %0d expected 1", vq.size() - base); end
    if (vq.size() > base) begin
      checks++; if (vq[base] !== 8'h41) begin errors++; $display("FAIL ovf_kept_byte: got %h expected 41", vq[base]); end
    end
    checks++; if (bus.OVF !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.OVF); end
  endtask

  task automatic test_timeout();
    int c0, t1, t2, base;
    bit ok;
    logic [7:0] d1, d2;
    do_reset();
    busy_len = 3;
    ignore_mode = 1'b1;
    base = vq.size();
    t1 = -1;
    t2 = -1;
    d1 = 8'h00;
    d2 = 8'h00;
    strobe_rf(8'h5A, c0);
    for (int i = 0; i < 40; i++) begin
      if (bus.TX_D_VALID === 1'b1) begin t1 = cyc; d1 = bus.TX_P_DATA; break; end
      @(negedge clk);
    end
    @(negedge clk);
    ignore_mode = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.TX_D_VALID === 1'b1) begin t2 = cyc; d2 = bus.TX_P_DATA; break; end
      @(negedge clk);
    end
    checks++; if (t2 - t1 != 16 || t1 < 0) begin errors++; $display("FAIL timeout_gap: got %0d expected 16", t2 - t1); end
    checks++; if (d1 !== 8'h5A) begin errors++; $display("FAIL timeout_byte1: got %h expected 5a", d1); end
    checks++; if (d2 !== 8'h5A) begin errors++; $display("FAIL timeout_byte2: got %h expected 5a", d2); end
    wait_idle(ok);
    checks++; if (vq.size() - base != 2) begin errors++; $display("FAIL timeout_pulse_count: got %0d expected 2", vq.size() - base); end
    checks++; if (bus.RF_FULL !== 1'b0) begin errors++; $display("FAIL timeout_release: got %b expected 0", bus.RF_FULL); end
  endtask

  task automatic test_reset_mid();
    int c0, n0;
    bit got;
    busy_len = 10;
    got = 1'b0;
    strobe_alu(16'h1234, c0);
    for (int i = 0; i < 40; i++) begin
      if (bus.TX_D_VALID === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++; if (!got || bus.TX_P_DATA !== 8'h34) begin errors++; $display("FAIL mid_pre_data: got %h expected 34", bus.TX_P_DATA); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.TX_P_DATA !== 8'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", bus.TX_P_DATA); end
    checks++; if (bus.ALU_FULL !== 1'b0) begin errors++; $display("FAIL mid_alu_full: got %b expected 0", bus.ALU_FULL); end
    checks++; if (bus.TX_D_VALID !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", bus.TX_D_VALID); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n0 = vq.size();
    repeat (30) @(negedge clk);
    checks++; if (vq.size() != n0) begin errors++; $display("FAIL mid_no_valid: got %0d pulses expected 0", vq.size() - n0); end
    checks++; if (bus.ALU_FULL !== 1'b0) begin errors++; $display("FAIL mid_alu_after: got %b expected 0", bus.ALU_FULL); end
  endtask

  initial begin
    test_reset();
    test_rf_single();
    test_alu();
    test_priority();
    test_coincident();
    test_ovf();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
